// File: rtl/downsizer_pkg.sv
// Shared types and elaboration-time helpers for the wide-to-narrow width converter.
package downsizer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int calc_ratio(input int inp_bytes, input int out_bytes);
        return inp_bytes / out_bytes;
    endfunction

    function automatic int calc_cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit is_pow2_ge2(input int ratio);
        return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
    endfunction

    // Bit offset of narrow beat k inside the wide word; beat 0 is the LS slice.
    function automatic int slice_lsb(input int k, input int out_bytes);
        return k * out_bytes * 8;
    endfunction

endpackage

// File: rtl/downsizer.sv
// Holds one wide word and replays it as 1..RATIO narrow beats, LS slice first,
// accepting the next word on the same edge the last beat leaves.
module downsizer
    import downsizer_pkg::*;
#(
    parameter int INP_DATA_WIDTH = 128,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int RATIO          = calc_ratio(INP_DATA_WIDTH, DATA_OUT_WIDTH),
    parameter int CNT_WIDTH      = calc_cnt_width(RATIO)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [INP_DATA_WIDTH*8-1:0] inp_data,
    input  logic                        inp_valid,
    input  logic [CNT_WIDTH:0]          inp_nbeats,
    output logic                        inp_ready,
    output logic [DATA_OUT_WIDTH*8-1:0] data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        nbeats_err
);

    localparam int INP_BITS = INP_DATA_WIDTH * 8;
    localparam int OUT_BITS = DATA_OUT_WIDTH * 8;
    localparam logic [CNT_WIDTH:0] RATIO_N = (CNT_WIDTH + 1)'(RATIO);
    localparam logic [CNT_WIDTH:0] ONE_N   = (CNT_WIDTH + 1)'(1);

    generate
        if (!is_pow2_ge2(RATIO)) begin : g_bad_ratio
            $error("downsizer: RATIO must be a power of two and at least 2");
        end
    endgenerate

    state_t                 state;
    logic [INP_BITS-1:0]    hold;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH:0]     nbeats_q;
    logic [OUT_BITS-1:0]    data_q;
    logic                   last_q;
    logic                   err_q;

    logic                   beat_xfer;
    logic                   accept;
    logic                   nbeats_bad;
    logic [CNT_WIDTH:0]     nbeats_clamped;
    logic [CNT_WIDTH:0]     cnt_nxt;

    assign out_valid  = (state == SEND);
    assign beat_xfer  = out_valid && out_ready;
    // Ready in SEND only while the final beat is leaving, giving zero-bubble handover.
    assign inp_ready  = rstn && ((state == IDLE) || (beat_xfer && last_q));
    assign accept     = inp_valid && inp_ready;

    assign nbeats_bad     = (inp_nbeats == '0) || (inp_nbeats > RATIO_N);
    assign nbeats_clamped = nbeats_bad ? RATIO_N : inp_nbeats;
    assign cnt_nxt        = {1'b0, beat_cnt} + ONE_N;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            hold     <= '0;
            beat_cnt <= '0;
            nbeats_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && nbeats_bad;
            if (accept) begin
                state    <= SEND;
                hold     <= inp_data;
                beat_cnt <= '0;
                nbeats_q <= nbeats_clamped;
                data_q   <= inp_data[OUT_BITS-1:0];
                last_q   <= (nbeats_clamped == ONE_N);
            end else if (beat_xfer) begin
                if (last_q) begin
                    state  <= IDLE;
                    data_q <= '0;
                    last_q <= 1'b0;
                end else begin
                    beat_cnt <= cnt_nxt[CNT_WIDTH-1:0];
                    data_q   <= hold[slice_lsb(int'(cnt_nxt), DATA_OUT_WIDTH) +: OUT_BITS];
                    last_q   <= (cnt_nxt == nbeats_q - ONE_N);
                end
            end
        end
    end

    assign data_out   = data_q;
    assign out_last   = last_q;
    assign nbeats_err = err_q;

endmodule

// File: tb/tb_downsizer.sv
// Directed table plus corner-case sequences and a randomized scoreboard run for downsizer.
module tb_downsizer;

    localparam int INB  = 128;
    localparam int OUTB = 32;

    logic                clk = 1'b0;
    logic                rstn;
    logic [INB*8-1:0]    inp_data;
    logic                inp_valid;
    logic [2:0]          inp_nbeats;
    logic                inp_ready;
    logic [OUTB*8-1:0]   data_out;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                nbeats_err;

    int total = 0;
    int bad   = 0;

    downsizer #(.INP_DATA_WIDTH(INB), .DATA_OUT_WIDTH(OUTB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inp_data   (inp_data),
        .inp_valid  (inp_valid),
        .inp_nbeats (inp_nbeats),
        .inp_ready  (inp_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .nbeats_err (nbeats_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [2:0] nbeats;
        int         exp_n;
        logic       exp_err;
    } vec_t;

    function automatic logic [INB*8-1:0] make_word(input logic [7:0] base);
        logic [INB*8-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < OUTB; b++)
                w[k*OUTB*8 + b*8 +: 8] = base + 8'(k);
        return w;
    endfunction

    function automatic logic [OUTB*8-1:0] exp_beat(input logic [7:0] base, input int k);
        logic [OUTB*8-1:0] r;
        for (int b = 0; b < OUTB; b++)
            r[b*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic check256(input string name, input logic [OUTB*8-1:0] act, input logic [OUTB*8-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Present one word with out_ready held high and check every beat it produces.
    task automatic run_word(input logic [7:0] base, input logic [2:0] nb, input int exp_n, input logic exp_err);
        int waitc;
        waitc = 0;
        @(negedge clk);
        inp_data   = make_word(base);
        inp_nbeats = nb;
        inp_valid  = 1'b1;
        out_ready  = 1'b1;
        #1;
        while (!inp_ready && waitc < 20) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        checkb("word_accept_ready", inp_ready, 1'b1);
        @(negedge clk);
        inp_valid = 1'b0;
        for (int k = 0; k < exp_n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checkb("beat_valid", out_valid, 1'b1);
            check256("beat_data", data_out, exp_beat(base, k));
            checkb("beat_last", out_last, k == exp_n - 1);
            checkb("beat_err", nbeats_err, (k == 0) ? exp_err : 1'b0);
            checkb("beat_inp_ready", inp_ready, k == exp_n - 1);
        end
        @(negedge clk);
        #1;
        checkb("word_end_valid", out_valid, 1'b0);
        check256("word_end_data", data_out, '0);
    endtask

    vec_t vecs[6];
    logic pat[7];
    logic [OUTB*8:0] q[$];

    initial begin
        vecs[0] = '{8'h00, 3'd4, 4, 1'b0};
        vecs[1] = '{8'h10, 3'd2, 2, 1'b0};
        vecs[2] = '{8'h20, 3'd0, 4, 1'b1};
        vecs[3] = '{8'h30, 3'd7, 4, 1'b1};
        vecs[4] = '{8'h40, 3'd1, 1, 1'b0};
        vecs[5] = '{8'h50, 3'd3, 3, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rstn = 1'b0; inp_data = '0; inp_valid = 1'b0; inp_nbeats = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        inp_valid = 1'b1;
        #1;
        checkb("rst_valid", out_valid, 1'b0);
        checkb("rst_last", out_last, 1'b0);
        checkb("rst_inp_ready", inp_ready, 1'b0);
        checkb("rst_err", nbeats_err, 1'b0);
        check256("rst_data", data_out, '0);
        inp_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++)
            run_word(vecs[i].base, vecs[i].nbeats, vecs[i].exp_n, vecs[i].exp_err);

        // Back-to-back words with inp_valid held: 8 contiguous beats.
        @(negedge clk);
        inp_data = make_word(8'h60); inp_nbeats = 3'd4; inp_valid = 1'b1; out_ready = 1'b1;
        #1;
        checkb("b2b_ready_idle", inp_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) inp_data = make_word(8'h70);
            if (i == 4) inp_valid = 1'b0;
            #1;
            checkb("b2b_valid", out_valid, 1'b1);
            check256("b2b_data", data_out, exp_beat((i < 4) ? 8'h60 : 8'h70, i % 4));
            checkb("b2b_last", out_last, (i % 4) == 3);
            checkb("b2b_inp_ready", inp_ready, (i % 4) == 3);
        end
        @(negedge clk);
        #1;
        checkb("b2b_end_valid", out_valid, 1'b0);

        // Backpressure: outputs hold while out_ready is low.
        begin
            int idx;
            idx = 0;
            @(negedge clk);
            inp_data = make_word(8'hB0); inp_nbeats = 3'd4; inp_valid = 1'b1; out_ready = 1'b1;
            #1;
            checkb("stall_accept", inp_ready, 1'b1);
            @(negedge clk);
            inp_valid = 1'b0;
            for (int j = 0; j < 7; j++) begin
                if (j > 0) @(negedge clk);
                out_ready = pat[j];
                #1;
                checkb("stall_valid", out_valid, 1'b1);
                check256("stall_data", data_out, exp_beat(8'hB0, idx));
                checkb("stall_last", out_last, idx == 3);
                checkb("stall_inp_ready", inp_ready, pat[j] && (idx == 3));
                if (pat[j]) idx++;
            end
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            checkb("stall_end_valid", out_valid, 1'b0);
            checki("stall_beats", idx, 4);
        end

        // Asynchronous reset mid-word, then a clean word.
        @(negedge clk);
        inp_data = make_word(8'h90); inp_nbeats = 3'd4; inp_valid = 1'b1; out_ready = 1'b1;
        #1;
        @(negedge clk);
        inp_valid = 1'b0;
        #1;
        check256("abort_beat0", data_out, exp_beat(8'h90, 0));
        @(negedge clk);
        #1;
        check256("abort_beat1", data_out, exp_beat(8'h90, 1));
        #2;
        rstn = 1'b0;
        #1;
        checkb("abort_valid", out_valid, 1'b0);
        checkb("abort_last", out_last, 1'b0);
        checkb("abort_inp_ready", inp_ready, 1'b0);
        check256("abort_data", data_out, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checkb("abort_idle", out_valid, 1'b0);
        run_word(8'hA0, 3'd4, 4, 1'b0);

        // Random traffic against a beat queue.
        begin
            int words_acc, err_exp, err_seen, cyc, n;
            logic [INB*8-1:0] w;
            logic [OUTB*8:0] e;
            words_acc = 0; err_exp = 0; err_seen = 0; cyc = 0;
            while (!((words_acc >= 2000) && (q.size() == 0)) && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                inp_valid = (words_acc < 2000) && ($urandom_range(0, 3) != 0);
                for (int i = 0; i < INB / 4; i++) w[i*32 +: 32] = $urandom;
                inp_data   = w;
                inp_nbeats = 3'($urandom_range(0, 7));
                out_ready  = ($urandom_range(0, 3) != 0) || (words_acc >= 2000);
                #1;
                if (nbeats_err) err_seen++;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checkb("rand_extra_beat", out_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check256("rand_data", data_out, e[OUTB*8-1:0]);
                        checkb("rand_last", out_last, e[OUTB*8]);
                    end
                end
                if (inp_valid && inp_ready) begin
                    n = (inp_nbeats == 0 || inp_nbeats > 4) ? 4 : int'(inp_nbeats);
                    if (inp_nbeats == 0 || inp_nbeats > 4) err_exp++;
                    for (int k = 0; k < n; k++)
                        q.push_back({(k == n - 1), inp_data[k*OUTB*8 +: OUTB*8]});
                    words_acc++;
                end
            end
            inp_valid = 1'b0;
            @(negedge clk);
            #1;
            if (nbeats_err) err_seen++;
            checki("rand_words", words_acc, 2000);
            checki("rand_queue_left", q.size(), 0);
            checki("rand_err_pulses", err_seen, err_exp);
            checkb("rand_end_valid", out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
